// File: rtl/led_pkg.sv
// Shared definitions for the LED serial driver: FSM states, default
// timing constants and the colour reordering used when a pixel is captured.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } led_state_e;

  localparam int DEF_T0H_CYC    = 40;
  localparam int DEF_T1H_CYC    = 80;
  localparam int DEF_BIT_CYC    = 125;
  localparam int DEF_LATCH_CYC  = 5000;
  localparam int BITS_PER_PIXEL = 24;

  // The strip wants green first, the selector delivers red first.
  function automatic logic [23:0] reorder_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Cycle counter for one bit window: flags the last cycle of the high phase
// (length chosen by the current bit) and the last cycle of the window.
module led_bit_timer
  import led_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_bit,
  output logic o_highEnd,
  output logic o_winEnd
);

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] T0_LAST  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1_LAST  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_highLast;

  assign w_highLast = i_bit ? T1_LAST : T0_LAST;
  assign o_highEnd  = i_run && (r_cnt == w_highLast);
  assign o_winEnd   = i_run && (r_cnt == WIN_LAST);

  // Held at zero whenever not transmitting so each pixel starts at cycle 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || o_winEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_serial_driver.sv
// Serial LED strip driver: accepts one 24-bit pixel at a time, sends it as
// pulse-width coded bits and ends a frame with a latch period of low output.
module led_serial_driver
  import led_pkg::*;
#(
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        valid,
  output logic        ready,
  output logic        dout,
  output logic        frame_done
);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_bit_timing
    $error("led_serial_driver: need 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (LATCH_CYC < 1) begin : g_bad_latch
    $error("led_serial_driver: need LATCH_CYC >= 1");
  end

  localparam int GW = $clog2(LATCH_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(LATCH_CYC - 1);
  localparam logic [4:0]    FIRST_BIT = 5'(BITS_PER_PIXEL - 1);

  led_state_e    r_state;
  logic [23:0]   r_shift;
  logic [4:0]    r_bitIdx;
  logic [GW-1:0] r_gapCnt;
  logic          r_dout;
  logic          r_ready;
  logic          r_frameDone;

  logic w_accept;
  logic w_run;
  logic w_highEnd;
  logic w_winEnd;

  assign w_accept = valid && r_ready;
  assign w_run    = (r_state == SEND);

  led_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_bit     (r_shift[23]),
    .o_highEnd (w_highEnd),
    .o_winEnd  (w_winEnd)
  );

  // Acceptance is only possible while ready, so checking it first gives it
  // priority over GAP expiry and makes chaining restart cleanly at bit 23.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitIdx    <= '0;
      r_gapCnt    <= '0;
      r_dout      <= 1'b0;
      r_ready     <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_accept) begin
        r_state  <= SEND;
        r_shift  <= reorder_grb(light);
        r_bitIdx <= FIRST_BIT;
        r_gapCnt <= '0;
        r_dout   <= 1'b1;
        r_ready  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dout <= 1'b0;
          end
          SEND: begin
            if (w_winEnd) begin
              if (r_bitIdx == 5'd0) begin
                r_state  <= GAP;
                r_dout   <= 1'b0;
                r_ready  <= 1'b1;
                r_gapCnt <= '0;
              end else begin
                r_shift  <= {r_shift[22:0], 1'b0};
                r_bitIdx <= r_bitIdx - 1'b1;
                r_dout   <= 1'b1;
              end
            end else if (w_highEnd) begin
              r_dout <= 1'b0;
            end
          end
          GAP: begin
            r_dout <= 1'b0;
            if (r_gapCnt == GAP_LAST) begin
              r_state     <= IDLE;
              r_gapCnt    <= '0;
              r_frameDone <= 1'b1;
            end else begin
              r_gapCnt <= r_gapCnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_dout  <= 1'b0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready      = r_ready;
  assign dout       = r_dout;
  assign frame_done = r_frameDone;

endmodule
